uart_autobaud_ctrl: RTL and testbench

- Configuration controller for the UART 16x baud clock generator.
- Measures the start-bit width of an incoming 0x55 sync character on the system clock.
- Computes the 13-bit baud divisor and the 3-bit eighth-fraction, then drives them to the baud generator.
- Gates the UART receive/transmit path off while calibration is in progress.

---
 rtl/uart_autobaud_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_uart_autobaud_ctrl.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_autobaud_ctrl.sv
// -----------------------------------------------------------------------------
// uart_autobaud_ctrl
//
// Purpose:
//   Configuration controller for the UART 16x baud clock generator. It times
//   the start bit of an incoming 0x55 sync character on clk and converts the
//   low-cycle count N into a 13-bit divisor (N/16 - 1) and a 3-bit
//   eighth-fraction (N[3:1]). The UART path is held off (o_uart_en low) while
//   a calibration is running.
//
// Optional feature (compile-time macro AUTOBAUD_AVERAGE_EN):
//   When defined, the second low pulse of 0x55 (bit1) is also timed. The two
//   widths are averaged, and a calibration whose pulse widths disagree by
//   more than a quarter of the first one is rejected with err = 11.
//   When undefined, only the start bit is measured and err = 11 never occurs.
//
// Ports:
//   clk                  in   system clock
//   aresetn              in   asynchronous active-low reset
//   i_start              in   single-cycle pulse, begins calibration
//   i_abort              in   single-cycle pulse, cancels calibration
//   i_rx                 in   raw serial input pin (asynchronous to clk)
//   o_baud_val[12:0]     out  divisor to the baud generator
//   o_baud_val_fraction  out  eighth-fraction to the baud generator
//   o_uart_en            out  high when the UART may use the baud outputs
//   o_busy               out  calibration in progress
//   o_locked             out  last calibration succeeded
//   o_err[1:0]           out  00 none, 01 too short, 10 overflow, 11 mismatch
// -----------------------------------------------------------------------------
module uart_autobaud_ctrl #(
    parameter int          CNT_W            = 17,
    parameter int          IDLE_CYCLES      = 64,
    parameter int          MIN_BIT_CLKS     = 32,
    parameter logic [12:0] DEFAULT_BAUD_VAL = 13'd26
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic        i_rx,
    output logic [12:0] o_baud_val,
    output logic [2:0]  o_baud_val_fraction,
    output logic        o_uart_en,
    output logic        o_busy,
    output logic        o_locked,
    output logic [1:0]  o_err
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] IDLE_TGT = CNT_W'(IDLE_CYCLES);
    localparam logic [CNT_W-1:0] MIN_BIT  = CNT_W'(MIN_BIT_CLKS);

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_SHORT    = 2'b01;
    localparam logic [1:0] ERR_OVF      = 2'b10;
    localparam logic [1:0] ERR_MISMATCH = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_IDLE,
        ST_WAIT_START,
        ST_MEASURE,
        ST_VALIDATE
`ifdef AUTOBAUD_AVERAGE_EN
        ,
        ST_GAP,
        ST_MEASURE2
`endif
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic             r_rx_meta;
    logic             r_rx_s;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_cnt_inc;

    logic [12:0]      r_baud_val;
    logic [12:0]      w_baud_val_next;
    logic [2:0]       r_frac;
    logic [2:0]       w_frac_next;
    logic             r_locked;
    logic             w_locked_next;
    logic [1:0]       r_err;
    logic [1:0]       w_err_next;

    // Measured bit time and the divisor derived from it
    logic [CNT_W-1:0] w_n;
    logic [CNT_W-5:0] w_n_quot;
    logic [12:0]      w_baud_calc;
    logic             w_mismatch;

    // -------------------------------------------------------------------------
    // Two-flop synchronizer; idles high so reset never looks like a start edge
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Saturating increment: the counter holds at all-ones instead of wrapping
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + CNT_ONE);

`ifdef AUTOBAUD_AVERAGE_EN
    logic [CNT_W-1:0] r_n1;
    logic [CNT_W-1:0] w_n1_next;
    logic [CNT_W:0]   w_sum;
    logic [CNT_W-1:0] w_diff;

    // In VALIDATE r_cnt holds the second pulse width N2
    assign w_sum      = {1'b0, r_n1} + {1'b0, r_cnt};
    assign w_n        = CNT_W'(w_sum >> 1);
    assign w_diff     = (r_n1 >= r_cnt) ? (r_n1 - r_cnt) : (r_cnt - r_n1);
    assign w_mismatch = (w_diff > (r_n1 >> 2));

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_n1 <= '0;
        end else begin
            r_n1 <= w_n1_next;
        end
    end
`else
    assign w_n        = r_cnt;
    assign w_mismatch = 1'b0;
`endif

    // Divisor is N/16 - 1; N >= MIN_BIT_CLKS keeps it non-zero
    assign w_n_quot    = w_n[CNT_W-1:4];
    assign w_baud_calc = 13'(w_n_quot) - 13'd1;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath registers follow the next-state logic
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_cnt      <= '0;
            r_baud_val <= DEFAULT_BAUD_VAL;
            r_frac     <= 3'd0;
            r_locked   <= 1'b0;
            r_err      <= ERR_NONE;
        end else begin
            r_cnt      <= w_cnt_next;
            r_baud_val <= w_baud_val_next;
            r_frac     <= w_frac_next;
            r_locked   <= w_locked_next;
            r_err      <= w_err_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath update logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_baud_val_next = r_baud_val;
        w_frac_next     = r_frac;
        w_locked_next   = r_locked;
        w_err_next      = r_err;
`ifdef AUTOBAUD_AVERAGE_EN
        w_n1_next       = r_n1;
`endif

        // Abort has priority over everything, including a pending commit
        if (i_abort && (r_state != ST_IDLE)) begin
            w_state_next  = ST_IDLE;
            w_locked_next = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start && !i_abort) begin
                        w_state_next  = ST_WAIT_IDLE;
                        w_cnt_next    = '0;
                        w_err_next    = ERR_NONE;
                        w_locked_next = 1'b0;
                    end
                end

                // Line must stay high for IDLE_CYCLES in a row before arming
                ST_WAIT_IDLE: begin
                    if (r_rx_s) begin
                        if (w_cnt_inc == IDLE_TGT) begin
                            w_state_next = ST_WAIT_START;
                            w_cnt_next   = '0;
                        end else begin
                            w_cnt_next = w_cnt_inc;
                        end
                    end else begin
                        w_cnt_next = '0;
                    end
                end

                // Every sample here was high, so a low sample is the falling edge
                ST_WAIT_START: begin
                    if (!r_rx_s) begin
                        w_state_next = ST_MEASURE;
                        w_cnt_next   = CNT_ONE;
                    end
                end

                ST_MEASURE: begin
                    if (r_rx_s) begin
`ifdef AUTOBAUD_AVERAGE_EN
                        w_n1_next    = r_cnt;
                        w_cnt_next   = CNT_ONE;
                        w_state_next = ST_GAP;
`else
                        w_state_next = ST_VALIDATE;
`endif
                    end else if (w_cnt_inc == CNT_MAX) begin
                        w_cnt_next   = w_cnt_inc;
                        w_err_next   = ERR_OVF;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_cnt_next = w_cnt_inc;
                    end
                end

`ifdef AUTOBAUD_AVERAGE_EN
                // High bit0 between the two low pulses
                ST_GAP: begin
                    if (!r_rx_s) begin
                        w_cnt_next   = CNT_ONE;
                        w_state_next = ST_MEASURE2;
                    end else if (w_cnt_inc == CNT_MAX) begin
                        w_cnt_next   = w_cnt_inc;
                        w_err_next   = ERR_OVF;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_cnt_next = w_cnt_inc;
                    end
                end

                ST_MEASURE2: begin
                    if (r_rx_s) begin
                        w_state_next = ST_VALIDATE;
                    end else if (w_cnt_inc == CNT_MAX) begin
                        w_cnt_next   = w_cnt_inc;
                        w_err_next   = ERR_OVF;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_cnt_next = w_cnt_inc;
                    end
                end
`endif

                // Failures leave the previous divisor in place
                ST_VALIDATE: begin
                    w_state_next = ST_IDLE;
                    if (w_mismatch) begin
                        w_err_next = ERR_MISMATCH;
                    end else if (w_n < MIN_BIT) begin
                        w_err_next = ERR_SHORT;
                    end else begin
                        w_baud_val_next = w_baud_calc;
                        w_frac_next     = w_n[3:1];
                        w_locked_next   = 1'b1;
                    end
                end

                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        o_busy    = (r_state != ST_IDLE);
        o_uart_en = (r_state == ST_IDLE);
    end

    assign o_baud_val          = r_baud_val;
    assign o_baud_val_fraction = r_frac;
    assign o_locked            = r_locked;
    assign o_err               = r_err;

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
`timescale 1ns/1ps
module tb_uart_autobaud_ctrl;

    localparam int SMALL_CNT_W = 13;
    localparam int SMALL_MAX   = (1 << SMALL_CNT_W) - 1;

    logic        clk     = 1'b0;
    logic        aresetn = 1'b0;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic        i_rx    = 1'b1;
    logic [12:0] o_baud_val;
    logic [2:0]  o_baud_val_fraction;
    logic        o_uart_en;
    logic        o_busy;
    logic        o_locked;
    logic [1:0]  o_err;

    // Narrow-counter instance used to reach counter saturation quickly
    logic        s_start = 1'b0;
    logic        s_abort = 1'b0;
    logic        s_rx    = 1'b1;
    logic [12:0] s_baud_val;
    logic [2:0]  s_baud_val_fraction;
    logic        s_uart_en;
    logic        s_busy;
    logic        s_locked;
    logic [1:0]  s_err;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct packed {
        logic [12:0] baud;
        logic [2:0]  frac;
        logic        locked;
        logic [1:0]  err;
    } res_t;

    res_t        sb_q[$];
    logic [12:0] m_baud = 13'd26;
    logic [2:0]  m_frac = 3'd0;

    always #5 clk = ~clk;

    uart_autobaud_ctrl dut (
        .clk                 (clk),
        .aresetn             (aresetn),
        .i_start             (i_start),
        .i_abort             (i_abort),
        .i_rx                (i_rx),
        .o_baud_val          (o_baud_val),
        .o_baud_val_fraction (o_baud_val_fraction),
        .o_uart_en           (o_uart_en),
        .o_busy              (o_busy),
        .o_locked            (o_locked),
        .o_err               (o_err)
    );

    uart_autobaud_ctrl #(.CNT_W(SMALL_CNT_W)) dut_small (
        .clk                 (clk),
        .aresetn             (aresetn),
        .i_start             (s_start),
        .i_abort             (s_abort),
        .i_rx                (s_rx),
        .o_baud_val          (s_baud_val),
        .o_baud_val_fraction (s_baud_val_fraction),
        .o_uart_en           (s_uart_en),
        .o_busy              (s_busy),
        .o_locked            (s_locked),
        .o_err               (s_err)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_rx(input logic v, input int n);
        i_rx = v;
        cyc(n);
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        cyc(1);
        i_start = 1'b0;
    endtask

    // Returns negedges waited until busy drops, or -1 when the budget expires
    task automatic wait_idle(input int budget, output int waited);
        waited = 0;
        while (o_busy && waited < budget) begin
            cyc(1);
            waited++;
        end
        if (o_busy) waited = -1;
    endtask

    // Expected outcome of one measured low width n
    task automatic predict_single(input int n);
        res_t r;
        if (n < 32) begin
            r = {m_baud, m_frac, 1'b0, 2'b01};
        end else begin
            m_baud = 13'(n / 16 - 1);
            m_frac = 3'((n % 16) / 2);
            r = {m_baud, m_frac, 1'b1, 2'b00};
        end
        sb_q.push_back(r);
    endtask

    task automatic test_reset();
        res_t got;
        cyc(3);
        got = {o_baud_val, o_baud_val_fraction, o_locked, o_err};
        n_compared++;
        if ({got, o_busy, o_uart_en} !== {13'd26, 3'd0, 1'b0, 2'b00, 1'b0, 1'b1}) begin
            n_mismatched++;
            $display("FAIL reset_values: got baud=%0d frac=%0d locked=%b err=%b busy=%b en=%b, want 26 0 0 00 0 1",
                     o_baud_val, o_baud_val_fraction, o_locked, o_err, o_busy, o_uart_en);
        end
        aresetn = 1'b1;
        cyc(200);
        got = {o_baud_val, o_baud_val_fraction, o_locked, o_err};
        n_compared++;
        if ({got, o_busy, o_uart_en, s_busy, s_baud_val} !==
            {13'd26, 3'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 13'd26}) begin
            n_mismatched++;
            $display("FAIL reset_hold: got baud=%0d frac=%0d locked=%b err=%b busy=%b en=%b sbusy=%b sbaud=%0d, want 26 0 0 00 0 1 0 26",
                     o_baud_val, o_baud_val_fraction, o_locked, o_err, o_busy, o_uart_en, s_busy, s_baud_val);
        end
        $display("txn reset baud=%0d frac=%0d", o_baud_val, o_baud_val_fraction);
    endtask

`ifndef AUTOBAUD_AVERAGE_EN
    task automatic test_boundaries();
        int   lens[6] = '{434, 20, 31, 32, 47, 1000};
        int   waited;
        res_t got;
        res_t exp_r;
        foreach (lens[k]) begin
            pulse_start();
            n_compared++;
            if ({o_busy, o_uart_en, o_locked, o_err} !== 5'b10_0_00) begin
                n_mismatched++;
                $display("FAIL start_state N=%0d: got busy=%b en=%b locked=%b err=%b, want 1 0 0 00",
                         lens[k], o_busy, o_uart_en, o_locked, o_err);
            end
            drive_rx(1'b1, 100);
            drive_rx(1'b0, lens[k]);
            predict_single(lens[k]);
            i_rx = 1'b1;
            wait_idle(20, waited);
            n_compared++;
            if (waited !== 4) begin
                n_mismatched++;
                $display("FAIL latency N=%0d: got %0d clk, want 4", lens[k], waited);
            end
            got   = {o_baud_val, o_baud_val_fraction, o_locked, o_err};
            exp_r = sb_q.pop_front();
            n_compared++;
            if (got !== exp_r) begin
                n_mismatched++;
                $display("FAIL result N=%0d: got baud=%0d frac=%0d locked=%b err=%b, want baud=%0d frac=%0d locked=%b err=%b",
                         lens[k], got.baud, got.frac, got.locked, got.err, exp_r.baud, exp_r.frac, exp_r.locked, exp_r.err);
            end
            $display("txn N=%0d baud=%0d frac=%0d locked=%b err=%b en=%b",
                     lens[k], o_baud_val, o_baud_val_fraction, o_locked, o_err, o_uart_en);
        end
    endtask

    // Low line at start, then a 63-high run and a short glitch must not arm
    task automatic test_idle_qualify();
        int   waited;
        res_t got;
        res_t exp_r;
        i_rx = 1'b0;
        cyc(5);
        pulse_start();
        drive_rx(1'b0, 500);
        drive_rx(1'b1, 63);
        drive_rx(1'b0, 10);
        drive_rx(1'b1, 64);
        drive_rx(1'b0, 868);
        n_compared++;
        if (o_busy !== 1'b1) begin
            n_mismatched++;
            $display("FAIL idle_busy: got busy=%b, want 1", o_busy);
        end
        predict_single(868);
        i_rx = 1'b1;
        wait_idle(20, waited);
        got   = {o_baud_val, o_baud_val_fraction, o_locked, o_err};
        exp_r = sb_q.pop_front();
        n_compared++;
        if (got !== exp_r || waited !== 4) begin
            n_mismatched++;
            $display("FAIL idle_result: got baud=%0d frac=%0d locked=%b err=%b lat=%0d, want baud=%0d frac=%0d locked=%b err=%b lat=4",
                     got.baud, got.frac, got.locked, got.err, waited, exp_r.baud, exp_r.frac, exp_r.locked, exp_r.err);
        end
        $display("txn N=868 baud=%0d frac=%0d locked=%b err=%b", o_baud_val, o_baud_val_fraction, o_locked, o_err);
    endtask

    task automatic test_abort();
        res_t got;
        res_t exp_r;
        // start and abort together while idle: start is dropped, lock kept
        i_start = 1'b1;
        i_abort = 1'b1;
        cyc(1);
        i_start = 1'b0;
        i_abort = 1'b0;
        n_compared++;
        if ({o_busy, o_locked, o_err, o_baud_val} !== {1'b0, 1'b1, 2'b00, m_baud}) begin
            n_mismatched++;
            $display("FAIL start_abort: got busy=%b locked=%b err=%b baud=%0d, want 0 1 00 %0d",
                     o_busy, o_locked, o_err, o_baud_val, m_baud);
        end
        pulse_start();
        drive_rx(1'b1, 80);
        drive_rx(1'b0, 100);
        sb_q.push_back({m_baud, m_frac, 1'b0, 2'b00});
        i_abort = 1'b1;
        cyc(1);
        i_abort = 1'b0;
        got   = {o_baud_val, o_baud_val_fraction, o_locked, o_err};
        exp_r = sb_q.pop_front();
        n_compared++;
        if ({got, o_busy, o_uart_en} !== {exp_r, 1'b0, 1'b1}) begin
            n_mismatched++;
            $display("FAIL abort: got baud=%0d frac=%0d locked=%b err=%b busy=%b en=%b, want baud=%0d frac=%0d locked=0 err=00 busy=0 en=1",
                     got.baud, got.frac, got.locked, got.err, o_busy, o_uart_en, exp_r.baud, exp_r.frac);
        end
        drive_rx(1'b0, 50);
        drive_rx(1'b1, 10);
        n_compared++;
        if ({o_busy, o_locked, o_baud_val} !== {1'b0, 1'b0, m_baud}) begin
            n_mismatched++;
            $display("FAIL abort_after: got busy=%b locked=%b baud=%0d, want 0 0 %0d", o_busy, o_locked, o_baud_val, m_baud);
        end
        $display("txn abort baud=%0d locked=%b err=%b", o_baud_val, o_locked, o_err);
    endtask

    // A stray start mid-measurement is ignored; second calibration follows at once
    task automatic test_back_to_back();
        int   lens[2] = '{434, 1000};
        int   waited;
        res_t got;
        res_t exp_r;
        foreach (lens[k]) begin
            pulse_start();
            drive_rx(1'b1, 70);
            if (k == 0) begin
                drive_rx(1'b0, 200);
                pulse_start();
                drive_rx(1'b0, 233);
            end else begin
                drive_rx(1'b0, lens[k]);
            end
            predict_single(lens[k]);
            i_rx = 1'b1;
            wait_idle(20, waited);
            got   = {o_baud_val, o_baud_val_fraction, o_locked, o_err};
            exp_r = sb_q.pop_front();
            n_compared++;
            if (got !== exp_r || waited !== 4) begin
                n_mismatched++;
                $display("FAIL b2b N=%0d: got baud=%0d frac=%0d locked=%b err=%b lat=%0d, want baud=%0d frac=%0d locked=%b err=%b lat=4",
                         lens[k], got.baud, got.frac, got.locked, got.err, waited, exp_r.baud, exp_r.frac, exp_r.locked, exp_r.err);
            end
            $display("txn b2b N=%0d baud=%0d frac=%0d locked=%b", lens[k], o_baud_val, o_baud_val_fraction, o_locked);
        end
    endtask
`else
    task automatic test_average();
        int   p1[4] = '{434, 430, 400, 860};
        int   p2[4] = '{600, 438, 500, 876};
        int   waited;
        int   diff;
        res_t got;
        res_t exp_r;
        foreach (p1[k]) begin
            pulse_start();
            drive_rx(1'b1, 80);
            drive_rx(1'b0, p1[k]);
            drive_rx(1'b1, p1[k]);
            drive_rx(1'b0, p2[k]);
            diff = (p1[k] > p2[k]) ? p1[k] - p2[k] : p2[k] - p1[k];
            if (diff > p1[k] / 4) sb_q.push_back({m_baud, m_frac, 1'b0, 2'b11});
            else predict_single((p1[k] + p2[k]) / 2);
            i_rx = 1'b1;
            wait_idle(20, waited);
            got   = {o_baud_val, o_baud_val_fraction, o_locked, o_err};
            exp_r = sb_q.pop_front();
            n_compared++;
            if (got !== exp_r || waited !== 4) begin
                n_mismatched++;
                $display("FAIL avg N1=%0d N2=%0d: got baud=%0d frac=%0d locked=%b err=%b lat=%0d, want baud=%0d frac=%0d locked=%b err=%b lat=4",
                         p1[k], p2[k], got.baud, got.frac, got.locked, got.err, waited, exp_r.baud, exp_r.frac, exp_r.locked, exp_r.err);
            end
            $display("txn avg N1=%0d N2=%0d baud=%0d frac=%0d locked=%b err=%b",
                     p1[k], p2[k], o_baud_val, o_baud_val_fraction, o_locked, o_err);
        end
    endtask
`endif

    // Reset mid-measurement returns outputs without waiting for a clock edge
    task automatic test_async_reset();
        pulse_start();
        drive_rx(1'b1, 80);
        drive_rx(1'b0, 100);
        #2 aresetn = 1'b0;
        #1;
        n_compared++;
        if ({o_baud_val, o_baud_val_fraction, o_locked, o_err, o_busy, o_uart_en} !==
            {13'd26, 3'd0, 1'b0, 2'b00, 1'b0, 1'b1}) begin
            n_mismatched++;
            $display("FAIL async_reset: got baud=%0d frac=%0d locked=%b err=%b busy=%b en=%b, want 26 0 0 00 0 1 (prior baud %0d)",
                     o_baud_val, o_baud_val_fraction, o_locked, o_err, o_busy, o_uart_en, m_baud);
        end
        @(negedge clk);
        i_rx    = 1'b1;
        aresetn = 1'b1;
        m_baud  = 13'd26;
        m_frac  = 3'd0;
        cyc(5);
        $display("txn async_reset baud=%0d busy=%b", o_baud_val, o_busy);
    endtask

    // Counter reaches all-ones on the narrow instance: overflow error
    task automatic test_overflow();
        int   waited;
        res_t got;
        res_t exp_r;
        s_start = 1'b1;
        cyc(1);
        s_start = 1'b0;
        s_rx    = 1'b1;
        cyc(80);
        s_rx = 1'b0;
        sb_q.push_back({13'd26, 3'd0, 1'b0, 2'b10});
        waited = 0;
        while (s_busy && waited < SMALL_MAX + 50) begin
            cyc(1);
            waited++;
        end
        n_compared++;
        if (waited !== SMALL_MAX + 2) begin
            n_mismatched++;
            $display("FAIL ovf_time: got %0d clk, want %0d", waited, SMALL_MAX + 2);
        end
        got   = {s_baud_val, s_baud_val_fraction, s_locked, s_err};
        exp_r = sb_q.pop_front();
        n_compared++;
        if ({got, s_busy} !== {exp_r, 1'b0}) begin
            n_mismatched++;
            $display("FAIL ovf_result: got baud=%0d frac=%0d locked=%b err=%b busy=%b, want baud=26 frac=0 locked=0 err=10 busy=0",
                     got.baud, got.frac, got.locked, got.err, s_busy);
        end
        s_rx = 1'b1;
        cyc(5);
        $display("txn overflow err=%b after %0d clk", s_err, waited);
    endtask

    initial begin
        test_reset();
`ifndef AUTOBAUD_AVERAGE_EN
        test_boundaries();
        test_idle_qualify();
        test_abort();
        test_back_to_back();
`else
        test_average();
`endif
        test_async_reset();
        test_overflow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got simulation still running at 3 ms, want completion");
        $fatal(1, "timeout");
    end

endmodule
